core_sequencer: RTL and testbench

CORE_SEQUENCER -- requirements
Module: core_sequencer

---
 rtl/core_sequencer.sv | 122 ++++++++++++
 tb/tb_core_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: fetch, execute, optional memory access, write-back.
// Sticky HALT/ERROR terminal states with a bounded wait on every memory handshake.
module core_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    output logic       imem_req,
    input  logic       imem_ready,
    output logic       inst_latch,
    input  logic       dec_wen,
    input  logic       dec_load,
    input  logic       dec_store,
    input  logic       dec_ebreak,
    input  logic       dec_illegal,
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ready,
    output logic       rf_we,
    output logic       pc_we,
    output logic       halted,
    output logic       err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5,
        S_ERROR = 3'd6,
        S_BAD   = 3'd7
    } state_e;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cnt_inc;
    logic       st_q, st_d;
    logic       run;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            st_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
        end
    end

    assign cnt_inc = cnt_q + 8'd1;

    // Ready on the cycle the counter would hit TIMEOUT still wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
                cnt_d   = 8'd0;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= TMO) state_d = S_ERROR;
                end
            end
            S_EXEC: begin
                st_d = dec_store;
                if (dec_illegal) begin
                    state_d = S_ERROR;
                end else if (dec_ebreak) begin
                    state_d = S_HALT;
                end else if (dec_load || dec_store) begin
                    state_d = S_MEM;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= TMO) state_d = S_ERROR;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                cnt_d   = 8'd0;
            end
            S_HALT:  state_d = S_HALT;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
    end

    // Reset masks every output so a late ready cannot produce a strobe.
    always_comb begin
        run        = ~rst;
        imem_req   = run & (state_q == S_FETCH);
        inst_latch = run & (state_q == S_FETCH) & imem_ready;
        dmem_req   = run & (state_q == S_MEM);
        dmem_we    = run & (state_q == S_MEM) & st_q;
        pc_we      = run & (state_q == S_WB);
        rf_we      = run & (state_q == S_WB) & dec_wen & ~dec_store;
        halted     = run & (state_q == S_HALT);
        err        = run & (state_q == S_ERROR);
        state      = state_q;
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench: expected output runs are queued by stimulus, a monitor
// compares each completed run (snapshot + length) as the DUT output changes.
module tb_core_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_req, imem_ready, inst_latch;
    logic       dec_wen, dec_load, dec_store, dec_ebreak, dec_illegal;
    logic       dmem_req, dmem_we, dmem_ready;
    logic       rf_we, pc_we, halted, err;
    logic [2:0] state;

    always #5 clk = ~clk;

    core_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ready(imem_ready), .inst_latch(inst_latch),
        .dec_wen(dec_wen), .dec_load(dec_load), .dec_store(dec_store),
        .dec_ebreak(dec_ebreak), .dec_illegal(dec_illegal),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .rf_we(rf_we), .pc_we(pc_we), .halted(halted), .err(err),
        .state(state)
    );

    typedef struct {
        logic [10:0] s;
        int          len;
    } exp_t;

    exp_t expq[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    // bits: ir il dr dw rw pw h e
    task automatic ex(input logic [2:0] st, input logic [7:0] o, input int len);
        exp_t e;
        e.s   = {st, o};
        e.len = len;
        expq.push_back(e);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [10:0] cur;
    int          run_len;
    bit          have = 1'b0;

    always @(negedge clk) begin
        logic [10:0] s;
        exp_t        e;
        if (mon_en) begin
            s = {state, imem_req, inst_latch, dmem_req, dmem_we,
                 rf_we, pc_we, halted, err};
            if (!have) begin
                cur = s;
                run_len = 1;
                have = 1'b1;
            end else if (s == cur) begin
                run_len++;
            end else begin
                n_vec++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_run: got %b x%0d, required none", cur, run_len);
                end else begin
                    e = expq.pop_front();
                    if (e.s !== cur || e.len != run_len) begin
                        n_err++;
                        $display("FAIL run_%0d: got %b x%0d, required %b x%0d",
                                 n_vec, cur, run_len, e.s, e.len);
                    end
                end
                cur = s;
                run_len = 1;
            end
        end
    end

    task automatic fetch_exec(input logic ld, input logic st, input logic wen);
        imem_ready = 1'b1;
        dec_load = ld; dec_store = st; dec_wen = wen;
        ex(3'd1, 8'b1100_0000, 1);
        tick();
        imem_ready = 1'b0;
        ex(3'd2, 8'b0000_0000, 1);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        dec_wen = 1'b0; dec_load = 1'b0; dec_store = 1'b0;
        dec_ebreak = 1'b0; dec_illegal = 1'b0;
        tick();
        mon_en = 1'b1;
        ex(3'd0, 8'b0000_0000, 2);
        tick();
        rst = 1'b0;
        tick();

        // ALU op with write
        fetch_exec(1'b0, 1'b0, 1'b1);
        ex(3'd4, 8'b0000_1100, 1);
        tick();

        // store, ready on 4th MEM cycle (counter boundary)
        fetch_exec(1'b0, 1'b1, 1'b1);
        ex(3'd3, 8'b0011_0000, 4);
        tick(3);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        ex(3'd4, 8'b0000_0100, 1);
        tick();

        // load, immediate ready
        fetch_exec(1'b1, 1'b0, 1'b1);
        ex(3'd3, 8'b0010_0000, 1);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        ex(3'd4, 8'b0000_1100, 1);
        tick();

        // load+store treated as store
        fetch_exec(1'b1, 1'b1, 1'b1);
        ex(3'd3, 8'b0011_0000, 1);
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        ex(3'd4, 8'b0000_0100, 1);
        tick();

        // ALU without write
        fetch_exec(1'b0, 1'b0, 1'b0);
        ex(3'd4, 8'b0000_0100, 1);
        tick();

        // fetch ready on 4th wait cycle, then illegal+ebreak -> ERROR
        ex(3'd1, 8'b1000_0000, 3);
        tick(3);
        dec_illegal = 1'b1; dec_ebreak = 1'b1;
        fetch_exec(1'b0, 1'b0, 1'b0);
        ex(3'd6, 8'b0000_0001, 4);
        tick(4);
        rst = 1'b1;
        ex(3'd6, 8'b0000_0000, 1);
        tick();
        rst = 1'b0;
        dec_illegal = 1'b0; dec_ebreak = 1'b0;
        ex(3'd0, 8'b0000_0000, 1);
        tick();

        // ebreak -> HALT held 20 cycles
        dec_ebreak = 1'b1;
        fetch_exec(1'b0, 1'b0, 1'b0);
        dec_ebreak = 1'b0;
        ex(3'd5, 8'b0000_0010, 20);
        tick(20);
        rst = 1'b1;
        ex(3'd5, 8'b0000_0000, 1);
        tick();
        rst = 1'b0;
        ex(3'd0, 8'b0000_0000, 1);
        tick();

        // fetch timeout
        ex(3'd1, 8'b1000_0000, 4);
        tick(4);
        ex(3'd6, 8'b0000_0001, 2);
        tick(2);
        rst = 1'b1;
        ex(3'd6, 8'b0000_0000, 1);
        tick();
        rst = 1'b0;
        ex(3'd0, 8'b0000_0000, 1);
        tick();

        // reset mid-MEM with ready pulse
        fetch_exec(1'b0, 1'b1, 1'b1);
        ex(3'd3, 8'b0011_0000, 1);
        tick();
        rst = 1'b1;
        dmem_ready = 1'b1;
        ex(3'd3, 8'b0000_0000, 1);
        tick();
        rst = 1'b0;
        dmem_ready = 1'b0;
        dec_store = 1'b0; dec_wen = 1'b0;
        ex(3'd0, 8'b0000_0000, 1);
        tick();
        ex(3'd1, 8'b1000_0000, 2);
        tick(2);
        rst = 1'b1;
        ex(3'd1, 8'b0000_0000, 1);
        tick();
        tick(2);

        n_vec++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d pending, required 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
